// File: rtl/syrup_mem_arbiter.sv
// syrup_mem_arbiter
// Round-robin arbiter that lets NUM_PORTS requesters share one single-port
// SyrupMemory1P. One request is accepted per cycle. The accepted access is
// registered onto the memory pins one cycle later. Each read carries its port
// index through a READ_LATENCY-deep tag pipeline, which routes MEM_Q back to
// the requester.
//
// Ports
//   CLK, RST     rising-edge clock; synchronous active-high reset
//   REQ_VALID    per-port request
//   REQ_WE       per-port type (1 = write, 0 = read)
//   REQ_ADDR     per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   REQ_D        per-port write data, packed like REQ_ADDR
//   REQ_READY    one-hot grant (combinational)
//   RESP_VALID   one-hot read-data strobe
//   RESP_Q       shared read data, qualified by RESP_VALID
//   MEM_*        SyrupMemory1P interface
module syrup_mem_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_PORTS-1:0]             REQ_VALID,
    input  logic [NUM_PORTS-1:0]             REQ_WE,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  REQ_D,
    output logic [NUM_PORTS-1:0]             REQ_READY,
    output logic [NUM_PORTS-1:0]             RESP_VALID,
    output logic [DATA_WIDTH-1:0]            RESP_Q,
    output logic [ADDR_WIDTH-1:0]            MEM_ADDR,
    output logic [DATA_WIDTH-1:0]            MEM_D,
    output logic                             MEM_WE,
    output logic                             MEM_RE,
    input  logic [DATA_WIDTH-1:0]            MEM_Q
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0]      r_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_d;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic [PTR_W-1:0]      r_issue_tag;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [PTR_W-1:0]      r_pipe_tag [READ_LATENCY];

    logic                  w_accept;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic                  w_resp_vld;

    // First valid port at or above r_ptr, wrapping around.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        w_accept  = 1'b0;
        w_gnt_idx = '0;
        v_idx     = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            v_idx = PTR_W'((32'(r_ptr) + k) % NUM_PORTS);
            if (!w_accept && REQ_VALID[v_idx]) begin
                w_accept  = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
        if (RST) begin
            w_accept = 1'b0;
        end
    end

    assign w_ptr_next = PTR_W'((32'(w_gnt_idx) + 32'd1) % NUM_PORTS);
    assign REQ_READY  = w_accept ? (NUM_PORTS'(1) << w_gnt_idx) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr       <= '0;
            r_mem_addr  <= '0;
            r_mem_d     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_issue_tag <= '0;
            r_pipe_vld  <= '0;
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                r_pipe_tag[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_ptr       <= w_ptr_next;
                r_mem_addr  <= REQ_ADDR[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_mem_d     <= REQ_D[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                r_mem_we    <= REQ_WE[w_gnt_idx];
                r_mem_re    <= ~REQ_WE[w_gnt_idx];
                r_issue_tag <= w_gnt_idx;
            end else begin
                r_mem_we    <= 1'b0;
                r_mem_re    <= 1'b0;
            end
            // Stage 0 is loaded in the MEM_RE cycle, so the last stage lines up
            // with MEM_Q READ_LATENCY cycles later.
            r_pipe_vld[0] <= r_mem_re;
            r_pipe_tag[0] <= r_issue_tag;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_tag[k] <= r_pipe_tag[k-1];
            end
        end
    end

    // Outputs are forced quiet for the whole time RST is high, not only after
    // the first reset edge.
    assign w_resp_vld = r_pipe_vld[READ_LATENCY-1] & ~RST;
    assign RESP_VALID = w_resp_vld ? (NUM_PORTS'(1) << r_pipe_tag[READ_LATENCY-1]) : '0;
    assign RESP_Q     = w_resp_vld ? MEM_Q : '0;
    assign MEM_ADDR   = RST ? '0 : r_mem_addr;
    assign MEM_D      = RST ? '0 : r_mem_d;
    assign MEM_WE     = r_mem_we & ~RST;
    assign MEM_RE     = r_mem_re & ~RST;

endmodule
